alu_cmd_sequencer: RTL and testbench

Command-side front end for the 4-bit combinational ALU datapath. Accepts operand/opcode commands over a valid/ready handshake and buffers them in a small FIFO. Issues each command to the ALU by driving its A/B/OP inputs for one cycle, captures the returned result with status flags, and presents it on a valid/ready response port. It turns the bare combinational ALU into a flow-controlled, back-pressurable unit usable by upstream sequential logic.

---
 rtl/alu_cmd_sequencer.sv | 140 ++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for a 4-bit combinational ALU: FIFO-buffered commands, one-cycle ALU issue, held response.
// Latency: a command accepted into an idle, empty unit yields rsp_valid two edges later; 2 cycles/response sustained.
// Backpressure: cmd_ready = !full (registered count only); the response is held stable until rsp_ready.
// Ports: clk/rst_n; cmd_* valid/ready command input; alu_* drive/return to the external ALU;
//        rsp_* valid/ready response output; fifo_count = current FIFO occupancy.
module alu_cmd_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [3:0]                 cmd_a,
  input  logic [3:0]                 cmd_b,
  input  logic [2:0]                 cmd_op,
  output logic [3:0]                 alu_a,
  output logic [3:0]                 alu_b,
  output logic [2:0]                 alu_op,
  input  logic [3:0]                 alu_result,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [3:0]                 rsp_result,
  output logic [2:0]                 rsp_op,
  output logic                       rsp_zero,
  output logic                       rsp_err,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
  } cmd_t;

  state_t          state_q, state_d;
  cmd_t            mem_q [DEPTH];
  cmd_t            mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [3:0]      rsp_result_q, rsp_result_d;
  logic [2:0]      rsp_op_q, rsp_op_d;
  logic            rsp_zero_q, rsp_zero_d;
  logic            rsp_err_q, rsp_err_d;

  cmd_t            head;
  logic            full, empty, push, pop, illegal;
  logic [3:0]      capt_result;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;
  // The FIFO is never empty in ISSUE, so every ISSUE cycle retires the head.
  assign pop       = (state_q == ISSUE);
  assign head      = mem_q[rd_ptr_q];

  assign illegal     = (head.op >= 3'b101);
  assign capt_result = illegal ? 4'h0 : alu_result;

  // ALU inputs are only non-zero during the single ISSUE cycle.
  assign alu_a  = (state_q == ISSUE) ? head.a  : 4'h0;
  assign alu_b  = (state_q == ISSUE) ? head.b  : 4'h0;
  assign alu_op = (state_q == ISSUE) ? head.op : 3'h0;

  assign rsp_valid  = (state_q == RESP);
  assign rsp_result = rsp_result_q;
  assign rsp_op     = rsp_op_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;
  assign fifo_count = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = '{a: cmd_a, b: cmd_b, op: cmd_op};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    rsp_result_d = rsp_result_q;
    rsp_op_d     = rsp_op_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (!empty) state_d = ISSUE;
      end
      ISSUE: begin
        rsp_result_d = capt_result;
        rsp_op_d     = head.op;
        rsp_zero_d   = (capt_result == 4'h0);
        rsp_err_d    = illegal;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = empty ? IDLE : ISSUE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rsp_result_q <= 4'h0;
      rsp_op_q     <= 3'h0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rsp_result_q <= rsp_result_d;
      rsp_op_q     <= rsp_op_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with an external behavioural ALU.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Response-port backpressure is exercised with held-low and random rsp_ready.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_a, cmd_b;
  logic [2:0] cmd_op;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic       rsp_valid, rsp_ready;
  logic [3:0] rsp_result;
  logic [2:0] rsp_op;
  logic       rsp_zero, rsp_err;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  alu_cmd_sequencer #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_op(rsp_op), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // External ALU; illegal opcodes return a non-zero value the sequencer must mask.
  always_comb begin
    case (alu_op)
      3'd0:    alu_result = alu_a + alu_b;
      3'd1:    alu_result = alu_a - alu_b;
      3'd2:    alu_result = alu_a & alu_b;
      3'd3:    alu_result = alu_a | alu_b;
      3'd4:    alu_result = alu_a ^ alu_b;
      default: alu_result = 4'h7;
    endcase
  end

  // Hand-computed command tables: {a, b, op, expected result}
  logic [3:0] bp_a   [5] = '{4'h1, 4'h7, 4'hC, 4'h5, 4'h3};
  logic [3:0] bp_b   [5] = '{4'h2, 4'h9, 4'hA, 4'hA, 4'h3};
  logic [2:0] bp_op  [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
  logic [3:0] bp_res [5] = '{4'h3, 4'hE, 4'h8, 4'hF, 4'h0};

  logic [3:0] wr_a   [10] = '{4'hC, 4'h9, 4'h8, 4'h0, 4'hF, 4'h3, 4'h6, 4'hA, 4'h5, 4'h1};
  logic [3:0] wr_b   [10] = '{4'h6, 4'h6, 4'h9, 4'h1, 4'h5, 4'h3, 4'h6, 4'h5, 4'hA, 4'h2};
  logic [2:0] wr_op  [10] = '{3'd2, 3'd3, 3'd0, 3'd1, 3'd4, 3'd7, 3'd1, 3'd0, 3'd2, 3'd3};
  logic [3:0] wr_res [10] = '{4'h4, 4'hF, 4'h1, 4'hF, 4'hA, 4'h0, 4'h0, 4'hF, 4'h0, 4'h3};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input logic [3:0] res, input logic [2:0] op,
                           input logic zero, input logic err);
    check({tag, ".valid"},  {31'd0, rsp_valid}, 32'd1);
    check({tag, ".result"}, {28'd0, rsp_result}, {28'd0, res});
    check({tag, ".op"},     {29'd0, rsp_op}, {29'd0, op});
    check({tag, ".zero"},   {31'd0, rsp_zero}, {31'd0, zero});
    check({tag, ".err"},    {31'd0, rsp_err}, {31'd0, err});
  endtask

  task automatic drive_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
  endtask

  initial begin
    int accepted, pushed, recv, cyc;
    logic acc;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b0;
    step(); step();
    check("reset.cmd_ready",  {31'd0, cmd_ready}, 32'd1);
    check("reset.rsp_valid",  {31'd0, rsp_valid}, 32'd0);
    check("reset.rsp_result", {28'd0, rsp_result}, 32'd0);
    check("reset.rsp_flags",  {27'd0, rsp_op, rsp_zero, rsp_err}, 32'd0);
    check("reset.alu",        {21'd0, alu_a, alu_b, alu_op}, 32'd0);
    check("reset.fifo_count", {29'd0, fifo_count}, 32'd0);
    rst_n = 1'b1;
    step();

    // Add 3+5: ISSUE one edge after accept, response two edges after.
    rsp_ready = 1'b1;
    drive_cmd(4'h3, 4'h5, 3'd0);
    step(); cmd_valid = 1'b0;
    check("add.count_after_push", {29'd0, fifo_count}, 32'd1);
    check("add.no_rsp_yet",       {31'd0, rsp_valid}, 32'd0);
    step();
    check("add.issue_alu", {21'd0, alu_a, alu_b, alu_op}, {21'd0, 4'h3, 4'h5, 3'd0});
    step();
    check_rsp("add", 4'h8, 3'd0, 1'b0, 1'b0);
    check("add.alu_idle", {21'd0, alu_a, alu_b, alu_op}, 32'd0);
    check("add.count_after_pop", {29'd0, fifo_count}, 32'd0);
    step();
    check("add.rsp_dropped", {31'd0, rsp_valid}, 32'd0);

    // Sub wrap followed back-to-back by xor to zero.
    drive_cmd(4'h2, 4'h3, 3'd1);
    step();
    drive_cmd(4'hA, 4'hA, 3'd4);
    step(); cmd_valid = 1'b0;
    step();
    check_rsp("sub", 4'hF, 3'd1, 1'b0, 1'b0);
    step();
    check("xor.gap_no_rsp", {31'd0, rsp_valid}, 32'd0);
    check("xor.issue_alu", {21'd0, alu_a, alu_b, alu_op}, {21'd0, 4'hA, 4'hA, 3'd4});
    step();
    check_rsp("xor", 4'h0, 3'd4, 1'b1, 1'b0);
    step();

    // Illegal opcode: ALU returns garbage, result forced to zero.
    drive_cmd(4'h9, 4'h4, 3'd6);
    step(); cmd_valid = 1'b0;
    step();
    check("illegal.alu_op", {29'd0, alu_op}, 32'd6);
    step();
    check_rsp("illegal", 4'h0, 3'd6, 1'b1, 1'b1);
    step();

    // Back-pressure: only DEPTH+1 commands accepted.
    rsp_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 10; i++) begin
      drive_cmd(bp_a[i % 5], bp_b[i % 5], bp_op[i % 5]);
      acc = cmd_ready;
      step();
      if (acc) accepted++;
    end
    cmd_valid = 1'b0;
    check("bp.accepted",   accepted, 32'd5);
    check("bp.count_full", {29'd0, fifo_count}, 32'd4);
    check("bp.cmd_ready",  {31'd0, cmd_ready}, 32'd0);
    step();
    check_rsp("bp.held", bp_res[0], bp_op[0], 1'b0, 1'b0);
    rsp_ready = 1'b1;
    step();
    check("bp.ready_still_low", {31'd0, cmd_ready}, 32'd0);
    step();
    check("bp.ready_after_pop", {31'd0, cmd_ready}, 32'd1);
    check("bp.count_after_pop", {29'd0, fifo_count}, 32'd3);
    recv = 1;
    cyc = 0;
    while (recv < 5 && cyc < 50) begin
      if (rsp_valid) begin
        check_rsp($sformatf("bp.rsp%0d", recv), bp_res[recv], bp_op[recv],
                  bp_res[recv] == 4'h0, 1'b0);
        recv++;
      end
      step();
      cyc++;
    end
    check("bp.all_received", recv, 32'd5);

    // Pointer wrap: concurrent push and random-ready drain of 10 commands.
    pushed = 0; recv = 0; cyc = 0;
    while ((pushed < 10 || recv < 10) && cyc < 400) begin
      acc = 1'b0;
      if (pushed < 10) begin
        drive_cmd(wr_a[pushed], wr_b[pushed], wr_op[pushed]);
        acc = cmd_ready;
      end else begin
        cmd_valid = 1'b0;
      end
      rsp_ready = 1'($urandom_range(0, 1));
      if (rsp_valid && rsp_ready) begin
        if (recv < 10) begin
          check($sformatf("wrap.res%0d", recv), {28'd0, rsp_result}, {28'd0, wr_res[recv]});
          check($sformatf("wrap.err%0d", recv), {31'd0, rsp_err}, {31'd0, wr_op[recv] >= 3'd5});
        end
        recv++;
      end
      step();
      if (acc) pushed++;
      cyc++;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    check("wrap.received", recv, 32'd10);
    step(); step(); step();
    check("wrap.no_dup_valid", {31'd0, rsp_valid}, 32'd0);
    check("wrap.empty",        {29'd0, fifo_count}, 32'd0);

    // Reset while in RESP with 3 entries queued.
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_cmd(4'(i + 1), 4'h0, 3'd0);
      step();
    end
    cmd_valid = 1'b0;
    check("rst.pre_valid", {31'd0, rsp_valid}, 32'd1);
    check("rst.pre_count", {29'd0, fifo_count}, 32'd3);
    rst_n = 1'b0;
    #1;
    check("rst.valid",     {31'd0, rsp_valid}, 32'd0);
    check("rst.count",     {29'd0, fifo_count}, 32'd0);
    check("rst.alu",       {21'd0, alu_a, alu_b, alu_op}, 32'd0);
    check("rst.result",    {28'd0, rsp_result}, 32'd0);
    check("rst.cmd_ready", {31'd0, cmd_ready}, 32'd1);
    #2;
    rst_n = 1'b1;
    step();
    rsp_ready = 1'b1;
    drive_cmd(4'h6, 4'h7, 3'd0);
    step(); cmd_valid = 1'b0;
    step();
    check("post_rst.no_rsp_yet", {31'd0, rsp_valid}, 32'd0);
    step();
    check_rsp("post_rst", 4'hD, 3'd0, 1'b0, 1'b0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
